// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader controller.
// Holds the controller state enumeration and the default parameter values.
package boot_pkg;

    localparam int unsigned IADDR_WIDTH_DEF   = 8;
    localparam int unsigned WIDTH_DEF         = 16;
    localparam int unsigned RELEASE_DELAY_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } boot_state_e;

endpackage : boot_pkg

// File: rtl/boot_load_ctrl.sv
// boot_load_ctrl: loads a program received over SPI into instruction memory,
// then releases the CPU from reset after a fixed delay.
// Ports:
//   clk, reset (async, active-low)
//   new_transfer, data_ready, data, transfer_done, chip_selected : SPI receiver side
//   iaddr_write, idata_write, i_write : instruction-memory write port (registered)
//   cpu_reset      : CPU reset, high unless running and not selected
//   word_count     : words accepted in the current/last load
//   load_error     : last load overflowed the instruction memory
module boot_load_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned iaddr_width   = IADDR_WIDTH_DEF,
    parameter int unsigned width         = WIDTH_DEF,
    parameter int unsigned release_delay = RELEASE_DELAY_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_transfer,
    input  logic                   data_ready,
    input  logic [width-1:0]       data,
    input  logic                   transfer_done,
    input  logic                   chip_selected,
    output logic [iaddr_width-1:0] iaddr_write,
    output logic [width-1:0]       idata_write,
    output logic                   i_write,
    output logic                   cpu_reset,
    output logic [iaddr_width:0]   word_count,
    output logic                   load_error
);

    localparam int unsigned CW = iaddr_width + 1;
    localparam logic [iaddr_width:0] MAX_WORDS  = {1'b1, {iaddr_width{1'b0}}};
    localparam logic [7:0]           DELAY_INIT = 8'(release_delay);

    boot_state_e state;
    logic [7:0]  delay_cnt;

    // Main controller: state, write port, word counter and release delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            iaddr_write <= '0;
            idata_write <= '0;
            i_write     <= 1'b0;
            word_count  <= '0;
            load_error  <= 1'b0;
            delay_cnt   <= '0;
        end else begin
            i_write <= 1'b0;
            if (new_transfer) begin
                // A new transfer restarts the load from any state; a word
                // arriving on the same edge is the first word of it.
                state      <= ST_LOAD;
                load_error <= 1'b0;
                if (data_ready) begin
                    i_write     <= 1'b1;
                    iaddr_write <= '0;
                    idata_write <= data;
                    word_count  <= CW'(1);
                end else begin
                    word_count  <= '0;
                end
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (data_ready && (word_count == MAX_WORDS)) begin
                            load_error <= 1'b1;
                            state      <= ST_ERROR;
                        end else begin
                            if (data_ready) begin
                                i_write     <= 1'b1;
                                iaddr_write <= word_count[iaddr_width-1:0];
                                idata_write <= data;
                                word_count  <= word_count + CW'(1);
                            end
                            if (transfer_done) begin
                                // Any word accepted on this edge counts as loaded.
                                if ((word_count == '0) && !data_ready) begin
                                    state <= ST_IDLE;
                                end else begin
                                    state     <= ST_HOLD;
                                    delay_cnt <= DELAY_INIT;
                                end
                            end
                        end
                    end
                    ST_HOLD: begin
                        delay_cnt <= delay_cnt - 8'd1;
                        if (delay_cnt <= 8'd1) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Chip select holds the CPU without waiting for a clock edge.
    assign cpu_reset = (state != ST_RUN) || chip_selected;

endmodule : boot_load_ctrl

// File: doc/boot_load_ctrl.md
BOOT_LOAD_CTRL -- requirements
Module: boot_load_ctrl

Interface
REQ-001 SHALL have parameter iaddr_width, default 8, meaning instruction-memory address width.
REQ-002 SHALL have parameter width, default 16, meaning instruction word width.
REQ-003 SHALL have parameter release_delay, default 4, meaning cycles between end of load and CPU release (range 1..255).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning reset: asynchronous, active-low.
REQ-006 SHALL have port new_transfer, input, 1, meaning a one-cycle pulse from the SPI receiver marking the start of a transfer.
REQ-007 SHALL have port data_ready, input, 1, meaning a one-cycle pulse marking that data is a valid word.
REQ-008 SHALL have port data, input, width, meaning the received word.
REQ-009 SHALL have port transfer_done, input, 1, meaning a one-cycle pulse marking the end of a transfer (chip deselected).
REQ-010 SHALL have port chip_selected, input, 1, meaning the SPI chip-select is active.
REQ-011 SHALL have port iaddr_write, output, iaddr_width, meaning the instruction-memory write address.
REQ-012 SHALL have port idata_write, output, width, meaning the instruction-memory write data.
REQ-013 SHALL have port i_write, output, 1, meaning the instruction-memory write strobe.
REQ-014 SHALL have port cpu_reset, output, 1, meaning the CPU reset, active-high.
REQ-015 SHALL have port word_count, output, iaddr_width+1, meaning the number of words accepted in the current or last load.
REQ-016 SHALL have port load_error, output, 1, meaning the last load overflowed the instruction memory.

Function
REQ-017 SHALL implement states IDLE, LOAD, HOLD, RUN and ERROR.
REQ-018 SHALL enter LOAD from any state on new_transfer, and on that edge clear word_count to 0 and load_error to 0.
REQ-019 SHALL, in LOAD, on data_ready with word_count < 2**iaddr_width, drive i_write=1 for exactly one cycle on the following cycle, with idata_write=data and iaddr_write=word_count[iaddr_width-1:0] (both registered), and then increment word_count; write latency is 1 cycle.
REQ-020 SHALL, in LOAD, on data_ready with word_count == 2**iaddr_width, suppress the write, set load_error=1 and go to ERROR.
REQ-021 SHALL, when new_transfer and data_ready occur in the same cycle, write the word at address 0 and leave word_count=1.
REQ-022 SHALL, in LOAD, on transfer_done, go to IDLE if word_count==0, else to HOLD with the delay counter loaded to release_delay.
REQ-023 SHALL, in HOLD, decrement the delay counter each cycle and go to RUN on the cycle it reaches 0; data_ready and transfer_done are ignored in HOLD.
REQ-024 SHALL ignore data_ready and transfer_done in IDLE, RUN and ERROR (i_write stays 0).
REQ-025 SHALL keep ERROR, with load_error=1, until new_transfer.
REQ-026 SHALL drive cpu_reset = (state != RUN) OR chip_selected, with the chip_selected term combinational so that the CPU is held with zero latency while selected.
REQ-027 SHALL drive i_write low except during the REQ-019 pulse; iaddr_write and idata_write hold their last values.
REQ-028 SHALL hold word_count after a load ends, for software and debug readback.

Reset
REQ-029 SHALL, on reset low, asynchronously force state=IDLE, iaddr_write=0, idata_write=0, i_write=0, word_count=0, load_error=0 and delay counter=0; cpu_reset is therefore 1.
REQ-030 SHALL treat reset asserted mid-LOAD or mid-HOLD the same as REQ-029; the partial program is invalid and the CPU stays in reset until a complete load.

Structure
REQ-031 SHALL place the state enumeration and the default constants (iaddr_width, width, release_delay) in the shared package boot_pkg.
REQ-032 SHALL be a single module with no sub-modules; the release-delay counter is inline.

Verification
REQ-033 SHALL cover: reset release, then 3 words 0x1111/0x2222/0x3333 -> writes at addresses 0/1/2, each 1 cycle after data_ready; word_count=3; cpu_reset falls exactly 4 cycles after transfer_done.
REQ-034 SHALL cover: 256 words, then a 257th data_ready -> no 257th write; load_error=1; state ERROR; cpu_reset stays 1 after transfer_done.
REQ-035 SHALL cover: a new transfer in RUN with 2 words -> cpu_reset=1 in the same cycle chip_selected rises; addresses restart at 0; word_count=2.
REQ-036 SHALL cover: new_transfer then transfer_done with no data -> state IDLE; cpu_reset stays 1; no i_write.
REQ-037 SHALL cover: reset asserted 2 cycles into HOLD -> all outputs at reset values immediately, without waiting for a clock edge; no release.
REQ-038 SHALL cover: new_transfer and data_ready=0xABCD in the same cycle -> write of 0xABCD at address 0; word_count=1.
